// File: rtl/branch_predictor_param_pkg.sv
// Shared mode constants and helpers for the parametrised branch predictor.
// Mode values are unique integers so MODE can be compared at elaboration time.
package branch_predictor_param_pkg;

  localparam int BPRED_ALWAYS_UNTAKEN     = 0;
  localparam int BPRED_ALWAYS_TAKEN       = 1;
  localparam int BPRED_SATURATION_COUNTER = 2;
  localparam int BPRED_HYSTERESIS_COUNTER = 3;
  localparam int BPRED_GSHARE             = 4;

  // Weakly not-taken: just below the taken half of the counter range.
  function automatic int weak_count(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_param_counter_next.sv
// Next-state logic for one BHT counter: saturating up/down, or the 2-bit
// hysteresis scheme where a wrong guess from a weak state jumps to the far strong state.
module bpred_counter_next #(
  parameter int COUNTER_BITS = 2,
  parameter bit HYSTERESIS   = 1'b0
) (
  input  logic [COUNTER_BITS-1:0] cur,
  input  logic                    taken,
  output logic [COUNTER_BITS-1:0] next
);

  if (HYSTERESIS) begin : g_hyst
    always_comb begin
      // NOTE: default assignment first so every path drives next and no latch is inferred.
      next = cur;
      case (cur)
        2'b00:   next = taken ? 2'b01 : 2'b00;
        2'b01:   next = taken ? 2'b11 : 2'b00;
        2'b10:   next = taken ? 2'b11 : 2'b00;
        default: next = taken ? 2'b11 : 2'b10;
      endcase
    end
  end else begin : g_sat
    always_comb begin
      next = cur;
      if (taken) begin
        if (cur != '1) next = cur + COUNTER_BITS'(1);
      end else if (cur != '0) begin
        next = cur - COUNTER_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor_param.sv
// Tagged BTB + per-entry BHT predictor with optional gshare hashing and
// branch/miss statistics. Lookup is combinational; resolution updates on the clock.
module branch_predictor_param
  import branch_predictor_param_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int INDEX_BITS   = 6,
  parameter int COUNTER_BITS = 2,
  parameter int MODE         = BPRED_HYSTERESIS_COUNTER,
  parameter int HIST_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] lk_pc,
  output logic                 lk_hit,
  output logic                 lk_taken,
  output logic [WORD_SIZE-1:0] lk_target,
  input  logic                 up_valid,
  input  logic [WORD_SIZE-1:0] up_pc,
  input  logic                 up_is_cond,
  input  logic                 up_taken,
  input  logic [WORD_SIZE-1:0] up_target,
  input  logic                 up_miss,
  output logic [WORD_SIZE-1:0] num_branch,
  output logic [WORD_SIZE-1:0] num_branch_miss
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
  localparam bit BTB_EN   = (MODE != BPRED_ALWAYS_UNTAKEN);
  localparam logic [COUNTER_BITS-1:0] CNT_WEAK = COUNTER_BITS'(weak_count(COUNTER_BITS));
  localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;

  if (COUNTER_BITS < 1 || COUNTER_BITS > 4) begin : g_bad_counter_bits
    $error("COUNTER_BITS must be in 1..4");
  end
  if (MODE == BPRED_HYSTERESIS_COUNTER && COUNTER_BITS != 2) begin : g_bad_hysteresis
    $error("hysteresis mode requires COUNTER_BITS == 2");
  end
  if (HIST_BITS > INDEX_BITS) begin : g_bad_hist_bits
    $error("HIST_BITS must not exceed INDEX_BITS");
  end

  logic                    valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]     tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0]    target_q [ENTRIES];
  logic [COUNTER_BITS-1:0] cnt_q    [ENTRIES];
  logic [HIST_BITS-1:0]    ghr_q, ghr_d;
  logic [WORD_SIZE-1:0]    num_branch_q, num_branch_miss_q;

  logic [INDEX_BITS-1:0]   hash;
  logic [INDEX_BITS-1:0]   lk_idx, up_idx;
  logic [TAG_BITS-1:0]     up_tag;
  logic                    up_taken_eff;
  logic [COUNTER_BITS-1:0] cnt_base, cnt_next, cnt_upd;

  assign hash = (MODE == BPRED_GSHARE) ? INDEX_BITS'(ghr_q) : '0;

  // Lookup path: reads registered state only, so a same-cycle update is not visible.
  assign lk_idx    = lk_pc[INDEX_BITS-1:0] ^ hash;
  assign lk_hit    = BTB_EN && valid_q[lk_idx] &&
                     (tag_q[lk_idx] == lk_pc[WORD_SIZE-1:INDEX_BITS]);
  assign lk_taken  = (MODE == BPRED_ALWAYS_UNTAKEN) ? 1'b0 :
                     (MODE == BPRED_ALWAYS_TAKEN)   ? lk_hit :
                     (lk_hit && cnt_q[lk_idx][COUNTER_BITS-1]);
  assign lk_target = lk_taken ? target_q[lk_idx] : lk_pc + WORD_SIZE'(1);

  // A replaced entry restarts from the weak value before the outcome is applied.
  assign up_idx       = up_pc[INDEX_BITS-1:0] ^ hash;
  assign up_tag       = up_pc[WORD_SIZE-1:INDEX_BITS];
  assign up_taken_eff = up_taken | ~up_is_cond;
  assign cnt_base     = (valid_q[up_idx] && tag_q[up_idx] == up_tag) ? cnt_q[up_idx] : CNT_WEAK;
  assign cnt_upd      = up_is_cond ? cnt_next : CNT_MAX;
  assign ghr_d        = (ghr_q << 1) | HIST_BITS'(up_taken);

  bpred_counter_next #(
    .COUNTER_BITS (COUNTER_BITS),
    .HYSTERESIS   (MODE == BPRED_HYSTERESIS_COUNTER)
  ) u_counter_next (
    .cur   (cnt_base),
    .taken (up_taken_eff),
    .next  (cnt_next)
  );

  // NOTE: tag/target storage is never read before its valid bit is set, so it carries
  // no reset and can map onto plain RAM; only valid bits and counters are cleared.
  always_ff @(posedge clk) begin
    if (BTB_EN && up_valid && !reset) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= up_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WEAK;
      end
      ghr_q             <= '0;
      num_branch_q      <= '0;
      num_branch_miss_q <= '0;
    end else if (up_valid) begin
      if (BTB_EN) begin
        valid_q[up_idx] <= 1'b1;
        cnt_q[up_idx]   <= cnt_upd;
      end
      if (up_is_cond) begin
        ghr_q        <= ghr_d;
        num_branch_q <= num_branch_q + WORD_SIZE'(1);
      end
      if (up_miss) num_branch_miss_q <= num_branch_miss_q + WORD_SIZE'(1);
    end
  end

  assign num_branch      = num_branch_q;
  assign num_branch_miss = num_branch_miss_q;

endmodule

// File: tb/tb_branch_predictor_param.sv
// Drives one predictor per mode from a shared stimulus stream and checks each
// against a table-level model every cycle, plus hand-computed spot values.
module tb_branch_predictor_param;
  import branch_predictor_param_pkg::*;

  localparam int NM = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] lk_pc;
  logic        up_valid, up_is_cond, up_taken, up_miss;
  logic [15:0] up_pc, up_target;

  logic [NM-1:0] hit, taken;
  logic [15:0]   tgt [NM];
  logic [15:0]   nb  [NM];
  logic [15:0]   nbm [NM];

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  // Instance g runs with MODE == g (the package constants are 0..4).
  for (genvar g = 0; g < NM; g++) begin : g_dut
    branch_predictor_param #(.MODE(g)) u_dut (
      .clk             (clk),
      .reset           (reset),
      .lk_pc           (lk_pc),
      .lk_hit          (hit[g]),
      .lk_taken        (taken[g]),
      .lk_target       (tgt[g]),
      .up_valid        (up_valid),
      .up_pc           (up_pc),
      .up_is_cond      (up_is_cond),
      .up_taken        (up_taken),
      .up_target       (up_target),
      .up_miss         (up_miss),
      .num_branch      (nb[g]),
      .num_branch_miss (nbm[g])
    );
  end

  // Reference model: one table per mode, plain integers.
  bit m_valid [NM][64];
  int m_tag   [NM][64];
  int m_tgt   [NM][64];
  int m_cnt   [NM][64];
  int m_ghr   [NM];
  int m_nb, m_nbm;

  function automatic int midx(input int m, input int pc);
    return (pc & 63) ^ ((m == BPRED_GSHARE) ? m_ghr[m] : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int m = 0; m < NM; m++) begin
        for (int e = 0; e < 64; e++) begin
          m_valid[m][e] = 1'b0;
          m_cnt[m][e]   = 1;
        end
        m_ghr[m] = 0;
      end
      m_nb  = 0;
      m_nbm = 0;
    end else if (up_valid) begin
      for (int m = 0; m < NM; m++) begin
        int i, base, c;
        if (m != BPRED_ALWAYS_UNTAKEN) begin
          i    = midx(m, int'(up_pc));
          base = (m_valid[m][i] && m_tag[m][i] == int'(up_pc) >> 6) ? m_cnt[m][i] : 1;
          if (!up_is_cond)                   c = 3;
          else if (m == BPRED_HYSTERESIS_COUNTER)
            c = up_taken ? ((base == 0) ? 1 : 3) : ((base == 3) ? 2 : 0);
          else
            c = up_taken ? ((base < 3) ? base + 1 : 3) : ((base > 0) ? base - 1 : 0);
          m_valid[m][i] = 1'b1;
          m_tag[m][i]   = int'(up_pc) >> 6;
          m_tgt[m][i]   = int'(up_target);
          m_cnt[m][i]   = c;
        end
        if (up_is_cond) m_ghr[m] = ((m_ghr[m] << 1) | int'(up_taken)) & 15;
      end
      if (up_is_cond) m_nb  = (m_nb + 1) & 16'hFFFF;
      if (up_miss)    m_nbm = (m_nbm + 1) & 16'hFFFF;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int m = 0; m < NM; m++) begin
        int i, etgt;
        bit eh, et;
        i  = midx(m, int'(lk_pc));
        eh = (m != BPRED_ALWAYS_UNTAKEN) && m_valid[m][i] && (m_tag[m][i] == int'(lk_pc) >> 6);
        if (m == BPRED_ALWAYS_UNTAKEN)    et = 1'b0;
        else if (m == BPRED_ALWAYS_TAKEN) et = eh;
        else                              et = eh && (m_cnt[m][i] >= 2);
        etgt = et ? m_tgt[m][i] : ((int'(lk_pc) + 1) & 16'hFFFF);
        check($sformatf("m%0d_hit", m),    32'(hit[m]),   32'(eh));
        check($sformatf("m%0d_taken", m),  32'(taken[m]), 32'(et));
        check($sformatf("m%0d_target", m), 32'(tgt[m]),   32'(etgt));
        check($sformatf("m%0d_nb", m),     32'(nb[m]),    32'(m_nb));
        check($sformatf("m%0d_nbm", m),    32'(nbm[m]),   32'(m_nbm));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [15:0] pc, input logic cond, input logic tk,
                     input logic [15:0] target, input logic miss);
    up_valid   = 1'b1;
    up_pc      = pc;
    up_is_cond = cond;
    up_taken   = tk;
    up_target  = target;
    up_miss    = miss;
    tick();
    up_valid   = 1'b0;
    up_miss    = 1'b0;
  endtask

  task automatic look(input logic [15:0] pc);
    lk_pc = pc;
    #1;
  endtask

  localparam int SAT = BPRED_SATURATION_COUNTER;
  localparam int HYS = BPRED_HYSTERESIS_COUNTER;
  localparam int GSH = BPRED_GSHARE;

  initial begin
    reset = 1'b1; lk_pc = '0; up_valid = 1'b0; up_pc = '0;
    up_is_cond = 1'b0; up_taken = 1'b0; up_target = '0; up_miss = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    look(16'h0010);
    check("t1_hit",    32'(hit[SAT]),   32'd0);
    check("t1_taken",  32'(taken[SAT]), 32'd0);
    check("t1_target", 32'(tgt[SAT]),   32'h0011);
    check("t1_nb",     32'(nb[SAT]),    32'd0);

    // Saturating: weak + taken -> taken, then two not-taken -> not taken
    upd(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b0);
    look(16'h0010);
    check("t2_hit",    32'(hit[SAT]),   32'd1);
    check("t2_taken",  32'(taken[SAT]), 32'd1);
    check("t2_target", 32'(tgt[SAT]),   32'h0040);
    check("t2_at_taken", 32'(taken[BPRED_ALWAYS_TAKEN]), 32'd1);
    upd(16'h0010, 1'b1, 1'b0, 16'h0040, 1'b0);
    upd(16'h0010, 1'b1, 1'b0, 16'h0040, 1'b0);
    check("t2_taken_after_nt", 32'(taken[SAT]), 32'd0);

    // Hysteresis walk from ST; unconditional with up_taken=0 still forces max
    upd(16'h0020, 1'b0, 1'b0, 16'h0123, 1'b0);
    look(16'h0020);
    check("t3_st",      32'(taken[HYS]), 32'd1);
    check("t3_st_tgt",  32'(tgt[HYS]),   32'h0123);
    upd(16'h0020, 1'b1, 1'b0, 16'h0123, 1'b0);
    check("t3_wt",  32'(taken[HYS]), 32'd1);
    upd(16'h0020, 1'b1, 1'b0, 16'h0123, 1'b0);
    check("t3_snt", 32'(taken[HYS]), 32'd0);
    upd(16'h0020, 1'b1, 1'b1, 16'h0123, 1'b0);
    check("t3_wnt", 32'(taken[HYS]), 32'd0);
    upd(16'h0020, 1'b1, 1'b1, 16'h0123, 1'b0);
    check("t3_st2", 32'(taken[HYS]), 32'd1);

    // Aliasing: 0x0050 replaces 0x0010, counter restarts weak then not-taken -> 00
    upd(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b0);
    upd(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b0);
    upd(16'h0050, 1'b1, 1'b0, 16'h0077, 1'b1);
    look(16'h0010);
    check("t4_old_hit",    32'(hit[SAT]), 32'd0);
    check("t4_old_target", 32'(tgt[SAT]), 32'h0011);
    look(16'h0050);
    check("t4_new_hit",   32'(hit[SAT]),   32'd1);
    check("t4_new_taken", 32'(taken[SAT]), 32'd0);
    check("t4_at_target", 32'(tgt[BPRED_ALWAYS_TAKEN]), 32'h0077);
    check("t4_au_hit",    32'(hit[BPRED_ALWAYS_UNTAKEN]), 32'd0);
    upd(16'h0050, 1'b1, 1'b1, 16'h0077, 1'b0);
    check("t4_cnt_was_00", 32'(taken[SAT]), 32'd0);

    // Same-cycle lookup/update: lookup shows pre-update contents
    look(16'h0030);
    up_valid = 1'b1; up_pc = 16'h0030; up_is_cond = 1'b0; up_target = 16'h0099;
    #1;
    check("t4_no_bypass", 32'(hit[SAT]), 32'd0);
    tick();
    up_valid = 1'b0;
    check("t4_after_write", 32'(tgt[SAT]), 32'h0099);

    // GSHARE alternating pattern after a mid-run reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_nb_reset", 32'(nb[GSH]), 32'd0);
    for (int k = 0; k < 8; k++) upd(16'h0008, 1'b1, (k % 2) == 0, 16'h0200, k < 2);
    look(16'h0008);
    check("t5_nb",      32'(nb[GSH]),    32'd8);
    check("t5_nbm",     32'(nbm[GSH]),   32'd2);
    check("t5_pred_t",  32'(taken[GSH]), 32'd1);
    check("t5_pred_tg", 32'(tgt[GSH]),   32'h0200);
    upd(16'h0008, 1'b1, 1'b1, 16'h0200, 1'b0);
    check("t5_pred_n",  32'(taken[GSH]), 32'd0);

    // Statistics wrap, then reset coincident with an update
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 65535; i++)
      upd(16'(i & 8'hFF), 1'b1, i[0], 16'(i), (i % 3) == 0);
    check("t6_nb_max", 32'(nb[SAT]), 32'hFFFF);
    upd(16'h0001, 1'b1, 1'b1, 16'h0005, 1'b0);
    check("t6_nb_wrap", 32'(nb[SAT]),  32'h0000);
    check("t6_nbm",     32'(nbm[SAT]), 32'd21845);
    reset = 1'b1;
    upd(16'h0030, 1'b1, 1'b1, 16'h0444, 1'b1);
    reset = 1'b0;
    look(16'h0030);
    check("t6_rst_hit",    32'(hit[BPRED_ALWAYS_TAKEN]), 32'd0);
    check("t6_rst_target", 32'(tgt[SAT]), 32'h0031);
    check("t6_rst_nb",     32'(nb[SAT]),  32'd0);
    check("t6_rst_nbm",    32'(nbm[SAT]), 32'd0);
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor_param.md
Name: branch_predictor_param

Overview:
- Parametrised branch prediction unit for the pipelined 16-bit CPU.
- Replaces the predictor logic embedded in the datapath, which was fixed-size and selected by mode.
- Provides a tagged BTB, a per-entry N-bit BHT with saturating or hysteresis update, an optional gshare index hash, and built-in branch/miss statistics counters.
- IF stage looks up combinationally; EX/ID resolution updates synchronously.

Parameters:
- WORD_SIZE, 16, PC/target width.
- INDEX_BITS, 6, BTB/BHT index width; the table has 2^INDEX_BITS entries.
- COUNTER_BITS, 2, BHT counter width; must be 1..4.
- MODE, `BPRED_HYSTERESIS_COUNTER, one of the following:
  - BPRED_ALWAYS_UNTAKEN
  - BPRED_ALWAYS_TAKEN
  - BPRED_SATURATION_COUNTER
  - BPRED_HYSTERESIS_COUNTER
  - BPRED_GSHARE
- HIST_BITS, 4, global history length; used only in BPRED_GSHARE; must be <= INDEX_BITS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- lk_pc  in  WORD_SIZE  IF-stage PC to predict.
- lk_hit  out  1  valid BTB entry with matching tag.
- lk_taken  out  1  predicted taken.
- lk_target  out  WORD_SIZE  predicted next PC: BTB target if lk_taken, else lk_pc+1.
- up_valid  in  1  resolved control-flow instruction this cycle.
- up_pc  in  WORD_SIZE  PC of the resolved instruction.
- up_is_cond  in  1  1 = conditional branch, 0 = unconditional jump/JAL/JPR/JRL.
- up_taken  in  1  actual outcome; ignored when up_is_cond=0 (treated as 1).
- up_target  in  WORD_SIZE  actual taken target.
- up_miss  in  1  the datapath flushed for this instruction.
- num_branch  out  WORD_SIZE  count of up_valid && up_is_cond.
- num_branch_miss  out  WORD_SIZE  count of up_valid && up_miss.

Behaviour:
- Index and tag:
  - Table index = pc[INDEX_BITS-1:0], XOR {0, ghr} in GSHARE mode.
  - Tag = pc[WORD_SIZE-1:INDEX_BITS], stored in full.
- Lookup is purely combinational from registered state, zero latency.
- lk_taken by MODE:
  - ALWAYS_UNTAKEN: always 0. BTB is not written; lk_hit reads 0.
  - ALWAYS_TAKEN: lk_hit.
  - Counter modes: lk_hit && counter MSB.
- Update on rising edge when up_valid && !reset:
  - Write valid=1, tag, and target at the index.
  - Tag mismatch (replacement): the counter is reinitialised to weak state, then the outcome is applied.
- Counter reset/weak value: 2^(COUNTER_BITS-1)-1 (weakly not-taken).
- Saturating update: taken ⇒ +1, clamped at max; not-taken ⇒ -1, clamped at 0.
- Hysteresis (COUNTER_BITS must be 2; otherwise elaboration error), coded as 00 SNT, 01 WNT, 10 WT, 11 ST:

  | State | taken | not-taken |
  |---|---|---|
  | SNT | WNT | SNT |
  | WNT | ST | SNT |
  | WT | ST | SNT |
  | ST | ST | WT |

- Unconditional update (up_is_cond=0): counter forced to max.
- GHR (HIST_BITS): updated non-speculatively only on up_valid && up_is_cond, as ghr <= {ghr[HIST_BITS-2:0], up_taken}.
  - Update index uses the pre-shift GHR.
- Same cycle lookup and update to the same entry: lookup returns the old contents; no bypass.
- Statistics: 16-bit counters that wrap 0xFFFF→0. A miss and a branch can both increment in one cycle.
- Reset, effective at the next edge and also if asserted mid-run:
  - All valid bits, counters to the weak value, ghr, and stats cleared.
  - An update coincident with reset is dropped.
  - Outputs after reset: lk_hit=0, lk_taken=0, lk_target=lk_pc+1, num_*=0.

Decomposition:
- The mode constants stay in constants.v; BPRED_GSHARE is added there with a new unique value.
- Counter next-state logic goes in a sub-module bpred_counter_next, parametrised by COUNTER_BITS and HYSTERESIS: combinational, inputs cur and taken, output next.
- Table arrays, GHR, and stats live in the top.

Test Plan:
1. Reset, then lk_pc=0x0010 → lk_hit=0, lk_taken=0, lk_target=0x0011, num_branch=0.
2. Saturating, INDEX_BITS=6: up_pc=0x0010, up_is_cond=1, up_taken=1, up_target=0x0040, for 1 cycle → lk_pc=0x0010 gives hit=1, taken=1 (01→10), target=0x0040. Two not-taken updates → taken=0.
3. Hysteresis: from ST, one not-taken → WT, still taken; a second not-taken → SNT. One taken → WNT, still not-taken; another taken → ST, taken.
4. Aliasing: train 0x0010 taken, then update 0x0050 (same index, different tag) not-taken → lookup 0x0010 hit=0, and 0x0050 has counter 00.
5. GSHARE, HIST_BITS=4: alternate taken/not-taken at 0x0008 for 8 updates → after warm-up, predictions match the pattern, and num_branch=8 with num_branch_miss tracking up_miss pulses.
6. Force num_branch to 0xFFFF via 65535 updates, then one more → wraps to 0x0000. Assert reset together with up_valid → no entry written, all counts 0.
